ad9518_spi_tx: RTL and testbench



---
 rtl/ad9518_spi_pkg.sv | 37 +++
 rtl/spi_bit_engine.sv | 130 +++++++++++++
 rtl/ad9518_spi_tx.sv | 89 ++++++++
 tb/tb_ad9518_spi_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9518_spi_pkg.sv
// Shared types and constants for the AD9518 serial config path.
package ad9518_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  // Default frame timing, in CLK_LOW cycles
  localparam int DEF_WORD_BITS = 24;
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_CS_SETUP  = 2;
  localparam int DEF_CS_HOLD   = 2;
  localparam int DEF_CS_GAP    = 4;

  // AD9518 frame layout: instruction (RW, W1:W0, address) then one data byte
  localparam int FRM_RW_BIT   = 23;
  localparam int FRM_W_MSB    = 22;
  localparam int FRM_W_LSB    = 21;
  localparam int FRM_ADDR_MSB = 20;
  localparam int FRM_ADDR_LSB = 8;
  localparam int FRM_DATA_MSB = 7;
  localparam int FRM_DATA_LSB = 0;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// Write-only 3-wire SPI frame engine: CS setup, MSB-first shift, CS hold, CS gap.
//
// state | meaning
// IDLE  | CS_N high, waiting for start_i
// SETUP | CS_N low, SCLK low, first bit already on SDIO
// SHIFT | SCLK low/high phases of CLK_DIV cycles each, SDIO advances on SCLK fall
// HOLD  | SCLK low after the last high phase, CS_N still low
// GAP   | CS_N high for CS_GAP cycles; a start at the exit edge chains the next frame
module spi_bit_engine
  import ad9518_spi_pkg::*;
#(
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int CS_SETUP  = DEF_CS_SETUP,
  parameter int CS_HOLD   = DEF_CS_HOLD,
  parameter int CS_GAP    = DEF_CS_GAP
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [WORD_BITS-1:0] data_i,
  output logic                 accept_o,
  output logic                 cs_n_o,
  output logic                 sclk_o,
  output logic                 sdio_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) + 1);
  localparam int BW = $clog2(WORD_BITS);

  spi_state_e           state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [WORD_BITS-1:0] sh_q;
  logic                 cs_n_q, sclk_q, sdio_q, done_q, busy_q;

  // A new frame can be taken when idle or on the last gap cycle
  assign accept_o = (state_q == IDLE) || ((state_q == GAP) && (cnt_q == '0));

  assign cs_n_o = cs_n_q;
  assign sclk_o = sclk_q;
  assign sdio_o = sdio_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

  // Frame sequencer; every pin is registered, phase timers are reloaded down-counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdio_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= SETUP;
            cnt_q   <= CW'(CS_SETUP - 1);
            sh_q    <= data_i;
            sdio_q  <= data_i[WORD_BITS-1];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q <= SHIFT;
            cnt_q   <= CW'(CLK_DIV - 1);
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (!sclk_q) begin
            sclk_q <= 1'b1;
            cnt_q  <= CW'(CLK_DIV - 1);
          end else if (bit_q == BW'(WORD_BITS - 1)) begin
            sclk_q  <= 1'b0;
            sdio_q  <= 1'b0;
            state_q <= HOLD;
            cnt_q   <= CW'(CS_HOLD - 1);
          end else begin
            sclk_q <= 1'b0;
            sdio_q <= sh_q[WORD_BITS-2];
            sh_q   <= sh_q << 1;
            bit_q  <= bit_q + BW'(1);
            cnt_q  <= CW'(CLK_DIV - 1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= GAP;
            cnt_q   <= CW'(CS_GAP - 1);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (start_i) begin
            state_q <= SETUP;
            cnt_q   <= CW'(CS_SETUP - 1);
            sh_q    <= data_i;
            sdio_q  <= data_i[WORD_BITS-1];
            cs_n_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ad9518_spi_tx.sv
// AD9518 config transmitter: CONFIG_EN edge detect and a one-deep pending slot
// in front of the SPI frame engine.
module ad9518_spi_tx
  import ad9518_spi_pkg::*;
#(
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int CS_SETUP  = DEF_CS_SETUP,
  parameter int CS_HOLD   = DEF_CS_HOLD,
  parameter int CS_GAP    = DEF_CS_GAP
) (
  input  logic                 CLK_LOW,
  input  logic                 RST_N,
  input  logic                 CONFIG_EN,
  input  logic [WORD_BITS-1:0] CONFIG_DATA,
  output logic                 SPI_CS_N,
  output logic                 SPI_SCLK,
  output logic                 SPI_SDIO,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 DROP
);

  logic                 en_q;
  logic                 pend_vld_q, pend_vld_d;
  logic [WORD_BITS-1:0] pend_q, pend_d;
  logic                 drop_q, drop_d;
  logic                 req, accept, eng_start, eng_busy;
  logic [WORD_BITS-1:0] eng_data;

  assign req       = CONFIG_EN & ~en_q;
  assign eng_start = accept & (pend_vld_q | req);
  assign eng_data  = pend_vld_q ? pend_q : CONFIG_DATA;

  // Pending slot: the held word always goes first; a newer word either waits or replaces it
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = 1'b0;
    if (accept) begin
      if (pend_vld_q) begin
        pend_vld_d = req;
        if (req) pend_d = CONFIG_DATA;
      end
    end else if (req) begin
      drop_d     = pend_vld_q;
      pend_vld_d = 1'b1;
      pend_d     = CONFIG_DATA;
    end
  end

  // Edge-detect history resets high so a level already up at reset release is ignored
  always_ff @(posedge CLK_LOW or negedge RST_N) begin
    if (!RST_N) begin
      en_q       <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      en_q       <= CONFIG_EN;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
    end
  end

  spi_bit_engine #(
    .WORD_BITS (WORD_BITS),
    .CLK_DIV   (CLK_DIV),
    .CS_SETUP  (CS_SETUP),
    .CS_HOLD   (CS_HOLD),
    .CS_GAP    (CS_GAP)
  ) u_engine (
    .clk_i    (CLK_LOW),
    .rst_ni   (RST_N),
    .start_i  (eng_start),
    .data_i   (eng_data),
    .accept_o (accept),
    .cs_n_o   (SPI_CS_N),
    .sclk_o   (SPI_SCLK),
    .sdio_o   (SPI_SDIO),
    .done_o   (DONE),
    .busy_o   (eng_busy)
  );

  assign BUSY = eng_busy | pend_vld_q;
  assign DROP = drop_q;

endmodule

// File: tb/tb_ad9518_spi_tx.sv
// Bench for ad9518_spi_tx: two instances (default timing and minimum timing),
// a timeline reference model feeding expected-word queues, and per-instance pin monitors.
`timescale 1ns/1ps
module tb_ad9518_spi_tx;

  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] en = 2'b11;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic [1:0] cs_n, sclk, sdio, busy, done, drop;

  int nvec = 0, nerr = 0;
  int tnow = 0;
  int cs_falls [2] = '{0, 0};
  int drop_seen [2] = '{0, 0};

  // reference model state: cycle at which the engine is next free, pending word, expected drops
  int t_free [2] = '{0, 0};
  bit pv [2] = '{0, 0};
  logic [W-1:0] pd [2];
  int ed [2] = '{0, 0};
  logic [W-1:0] exp_q0 [$];
  logic [W-1:0] exp_q1 [$];

  always #5 clk = ~clk;

  ad9518_spi_tx #(.WORD_BITS(W), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut0 (
    .CLK_LOW(clk), .RST_N(rst_n), .CONFIG_EN(en[0]), .CONFIG_DATA(data0),
    .SPI_CS_N(cs_n[0]), .SPI_SCLK(sclk[0]), .SPI_SDIO(sdio[0]),
    .BUSY(busy[0]), .DONE(done[0]), .DROP(drop[0]));

  ad9518_spi_tx #(.WORD_BITS(W), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut1 (
    .CLK_LOW(clk), .RST_N(rst_n), .CONFIG_EN(en[1]), .CONFIG_DATA(data1),
    .SPI_CS_N(cs_n[1]), .SPI_SCLK(sclk[1]), .SPI_SDIO(sdio[1]),
    .BUSY(busy[1]), .DONE(done[1]), .DROP(drop[1]));

  // CS_N low time and full frame+gap period from the timing parameters of each instance
  function automatic int cslow(input int i);
    return (i == 0) ? (2 + 2 * 4 * W + 2) : (1 + 2 * 1 * W + 1);
  endfunction
  function automatic int period(input int i);
    return cslow(i) + ((i == 0) ? 4 : 1);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic [W-1:0] d);
    if (i == 0) exp_q0.push_back(d);
    else exp_q1.push_back(d);
  endtask

  task automatic pop_exp(input int i, output bit ok, output logic [W-1:0] d);
    ok = 1'b0;
    d = '0;
    if (i == 0 && exp_q0.size() > 0) begin d = exp_q0.pop_front(); ok = 1'b1; end
    if (i == 1 && exp_q1.size() > 0) begin d = exp_q1.pop_front(); ok = 1'b1; end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // pending word starts as soon as the engine frees up
  task automatic model_adv(input int i, input int t);
    if (pv[i] && t_free[i] <= t) begin
      push_exp(i, pd[i]);
      t_free[i] = t_free[i] + period(i);
      pv[i] = 1'b0;
    end
  endtask

  task automatic model_req(input int i, input int t, input logic [W-1:0] d);
    model_adv(i, t);
    if (!pv[i] && t >= t_free[i]) begin
      push_exp(i, d);
      t_free[i] = t + period(i);
    end else if (pv[i]) begin
      ed[i]++;
      pd[i] = d;
    end else begin
      pv[i] = 1'b1;
      pd[i] = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    tnow++;
    model_adv(0, tnow);
    model_adv(1, tnow);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // raise CONFIG_EN for hi cycles (edge seen at the next clock), then drop it for one
  task automatic req(input int i, input logic [W-1:0] d, input int hi);
    if (i == 0) data0 = d; else data1 = d;
    en[i] = 1'b1;
    model_req(i, tnow + 1, d);
    repeat (hi) step();
    en[i] = 1'b0;
    step();
  endtask

  task automatic drain(input int i);
    int k;
    k = 0;
    while ((busy[i] || qsize(i) > 0) && k < 3000) begin
      step();
      k++;
    end
    if (k >= 3000) chk($sformatf("drain_timeout_i%0d", i), k, 0);
    idle(3);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    int low_cnt = 0, bits = 0, busy_len = 0, frames = 0;
    logic [W-1:0] word = '0;
    logic [W-1:0] expw;
    bit ok;
    logic p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0, in_frame = 1'b0;

    always @(negedge clk) begin
      if (!rst_n) begin
        low_cnt = 0; bits = 0; busy_len = 0; frames = 0;
        p_cs = 1'b1; p_sclk = 1'b0; p_busy = 1'b0; in_frame = 1'b0;
      end else begin
        if (p_cs && !cs_n[g]) begin
          in_frame = 1'b1; low_cnt = 0; bits = 0; word = '0;
          cs_falls[g]++;
        end
        if (!cs_n[g]) begin
          low_cnt++;
          if (!p_sclk && sclk[g]) begin
            word = {word[W-2:0], sdio[g]};
            bits++;
          end
        end else if (sclk[g]) begin
          chk($sformatf("sclk_with_cs_high_i%0d", g), 1, 0);
        end
        if (!p_cs && cs_n[g] && in_frame) begin
          chk($sformatf("done_at_cs_rise_i%0d", g), int'(done[g]), 1);
          chk($sformatf("sclk_rises_i%0d", g), bits, W);
          chk($sformatf("cs_low_cycles_i%0d", g), low_cnt, cslow(g));
          pop_exp(g, ok, expw);
          if (!ok) chk($sformatf("unexpected_frame_i%0d", g), int'(word), -1);
          else chk($sformatf("frame_word_i%0d", g), int'(word), int'(expw));
          chk($sformatf("sdio_idle_after_i%0d", g), int'(sdio[g]), 0);
          frames++;
          in_frame = 1'b0;
        end else if (done[g]) begin
          chk($sformatf("stray_done_i%0d", g), 1, 0);
        end
        if (drop[g]) drop_seen[g]++;
        if (busy[g]) busy_len++;
        else if (p_busy) begin
          chk($sformatf("busy_len_i%0d", g), busy_len, frames * period(g));
          busy_len = 0;
          frames = 0;
        end
        p_cs = cs_n[g]; p_sclk = sclk[g]; p_busy = busy[g];
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_cs_n", int'(cs_n), 3);
    chk("reset_busy", int'(busy), 0);

    // CONFIG_EN already high at reset release: no frame
    idle(500);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("no_frame_en_high_i%0d", i), cs_falls[i], 0);
      chk($sformatf("idle_busy_i%0d", i), int'(busy[i]), 0);
    end
    en = 2'b00;
    idle(2);

    // single frame, default timing
    req(0, 24'h00107C, 3);
    drain(0);

    // second request 50 cycles into the first frame
    req(0, 24'h00107C, 1);
    idle(47);
    req(0, 24'h0018A5, 1);
    drain(0);
    chk("no_drop_two_edges", drop_seen[0], 0);

    // three requests in one frame: middle word lost
    req(0, 24'h000111, 1);
    idle(20);
    req(0, 24'h000222, 1);
    idle(20);
    req(0, 24'h000333, 2);
    drain(0);
    chk("one_drop_three_edges", drop_seen[0], 1);

    // reset about 100 cycles into a frame
    req(0, 24'hA5C3F0, 1);
    idle(98);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", int'(cs_n[0]), 1);
    chk("midrst_sclk", int'(sclk[0]), 0);
    chk("midrst_sdio", int'(sdio[0]), 0);
    chk("midrst_busy", int'(busy[0]), 0);
    exp_q0.delete();
    pv[0] = 1'b0;
    t_free[0] = 0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    req(0, 24'h5A3C0F, 1);
    drain(0);

    // minimum timing: single frame, then a request landing exactly on the gap-exit edge
    req(1, 24'hC0FFEE, 1);
    drain(1);
    req(1, 24'h123456, 1);
    req(1, 24'h654321, 1);
    idle(period(1) - 4);
    req(1, 24'hABCDEF, 1);
    drain(1);
    chk("no_drop_gap_exit", drop_seen[1], 0);

    // random traffic on both instances
    for (int i = 0; i < 2; i++) begin
      repeat (30) begin
        idle($urandom_range(0, period(i) + 10));
        req(i, W'($urandom), $urandom_range(1, 3));
      end
      drain(i);
    end

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("frames_outstanding_i%0d", i), qsize(i), 0);
      chk($sformatf("drop_count_i%0d", i), drop_seen[i], ed[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
